// File: rtl/xaddr_router_pkg.sv
// Shared definitions for xaddr_router.
//   - xr_state_e     : router FSM state encodings (XR_ST_*)
//   - XR_ERR_*       : completion error codes reported on err_code
//   - XR_*_BASE      : default address tags of the standard slaves
//   - XR_DEF_SLV_BASE: default flattened tag table, slot 0 in the LSBs
package xaddr_router_pkg;

    typedef enum logic [1:0] {
        XR_ST_IDLE = 2'd0,
        XR_ST_REQ  = 2'd1,
        XR_ST_RESP = 2'd2,
        XR_ST_TRAP = 2'd3
    } xr_state_e;

    localparam logic [1:0] XR_ERR_OK    = 2'd0;
    localparam logic [1:0] XR_ERR_UNMAP = 2'd1;
    localparam logic [1:0] XR_ERR_TMO   = 2'd2;

    localparam int         XR_TAG_W     = 4;
    localparam logic [3:0] XR_MEM_BASE  = 4'h0;
    localparam logic [3:0] XR_REGF_BASE = 4'h1;
    localparam logic [3:0] XR_CPRT_BASE = 4'h2;
    localparam logic [3:0] XR_EXT_BASE  = 4'h3;

    localparam logic [4*XR_TAG_W-1:0] XR_DEF_SLV_BASE =
        {XR_EXT_BASE, XR_CPRT_BASE, XR_REGF_BASE, XR_MEM_BASE};

endpackage

// File: rtl/xrouter_wdog.sv
// Slave-ready watchdog for xaddr_router.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the count to zero (held while not waiting on a slave)
//   en         : count one more cycle without ready
//   expired    : count has reached TIMEOUT_CYC-1
module xrouter_wdog #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/xaddr_router.sv
// Address-tag router: forwards one master request to one of N_SLV slaves
// with a valid/ready handshake and a registered read-data return.
// Unmapped tags (and slave timeouts when XROUTER_TIMEOUT_EN is defined)
// complete with a one-cycle trap pulse.
//   clk, rst_n          : clock, asynchronous active-low reset
//   m_valid/m_addr/m_we : master request, sampled only when m_ready=1
//   m_ready             : router idle and able to accept
//   m_rvalid/m_rdata    : one-cycle completion pulse with read data
//   trap/err_code       : error pulse and code, valid with m_rvalid
//   s_valid             : one-hot slave request
//   s_ready/s_rdata     : slave done with read data in the same cycle
// Macro XROUTER_TIMEOUT_EN: enables the slave-ready watchdog (err_code=2).
module xaddr_router
    import xaddr_router_pkg::*;
#(
    parameter int                          ADDR_W      = 32,
    parameter int                          SEL_ADDR_W  = 4,
    parameter int                          DATA_W      = 32,
    parameter int                          N_SLV       = 4,
    parameter logic [N_SLV*SEL_ADDR_W-1:0] SLV_BASE    = XR_DEF_SLV_BASE,
    parameter int                          TIMEOUT_CYC = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m_valid,
    input  logic [ADDR_W-1:0]       m_addr,
    input  logic                    m_we,
    output logic                    m_ready,
    output logic                    m_rvalid,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    trap,
    output logic [1:0]              err_code,
    output logic [N_SLV-1:0]        s_valid,
    input  logic [N_SLV-1:0]        s_ready,
    input  logic [N_SLV*DATA_W-1:0] s_rdata
);
    localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    xr_state_e         state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d, hit_sel;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;

    logic [SEL_ADDR_W-1:0] tag;
    logic [N_SLV-1:0]      hit;
    logic                  any_hit;
    logic                  sel_ready;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  tmo;

    // Only the tag bits take part in routing.
    logic unused_addr;
    assign unused_addr = ^m_addr[ADDR_W-SEL_ADDR_W-1:0];

    assign tag = m_addr[ADDR_W-1 -: SEL_ADDR_W];

    // Tag 0 always reaches slot 0 regardless of its table entry.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N_SLV; i++)
            hit[i] = (tag == SLV_BASE[i*SEL_ADDR_W +: SEL_ADDR_W]);
        hit[0] = hit[0] | (tag == '0);
    end

    // Lowest matching slot wins when several table entries alias.
    always_comb begin
        hit_sel = '0;
        for (int i = N_SLV - 1; i >= 0; i--)
            if (hit[i]) hit_sel = SEL_W'(i);
    end

    assign any_hit   = |hit;
    assign sel_ready = s_ready[sel_q];
    assign sel_rdata = s_rdata[sel_q*DATA_W +: DATA_W];

`ifdef XROUTER_TIMEOUT_EN
    logic wd_clr, wd_en;
    // Held clear outside REQ so every REQ entry starts from zero.
    assign wd_clr = (state_q != XR_ST_REQ);
    assign wd_en  = (state_q == XR_ST_REQ) && !sel_ready;

    xrouter_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            XR_ST_IDLE: begin
                if (m_valid) begin
                    we_d  = m_we;
                    sel_d = hit_sel;
                    if (any_hit) begin
                        state_d = XR_ST_REQ;
                    end else begin
                        state_d = XR_ST_TRAP;
                        err_d   = XR_ERR_UNMAP;
                    end
                end
            end
            XR_ST_REQ: begin
                // Ready on the expiry cycle still completes normally.
                if (sel_ready) begin
                    rdata_d = we_q ? '0 : sel_rdata;
                    state_d = XR_ST_RESP;
                end else if (tmo) begin
                    state_d = XR_ST_TRAP;
                    err_d   = XR_ERR_TMO;
                end
            end
            XR_ST_RESP: state_d = XR_ST_IDLE;
            XR_ST_TRAP: state_d = XR_ST_IDLE;
            default:    state_d = XR_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= XR_ST_IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= XR_ERR_OK;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign m_ready  = (state_q == XR_ST_IDLE);
    assign m_rvalid = (state_q == XR_ST_RESP) || (state_q == XR_ST_TRAP);
    assign trap     = (state_q == XR_ST_TRAP);
    assign m_rdata  = (state_q == XR_ST_RESP) ? rdata_q : '0;
    assign err_code = (state_q == XR_ST_TRAP) ? err_q : XR_ERR_OK;
    assign s_valid  = (state_q == XR_ST_REQ) ? (N_SLV'(1) << sel_q) : '0;

endmodule

// File: tb/tb_xaddr_router.sv
module tb_xaddr_router;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         m_valid = 1'b0;
    logic [31:0]  m_addr = '0;
    logic         m_we = 1'b0;
    logic         m_ready, m_rvalid, trap;
    logic [31:0]  m_rdata;
    logic [1:0]   err_code;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready = '0;
    logic [127:0] s_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // slot0=5, slot1=1, slot2=2, slot3=1 (tag 1 aliased in slots 1 and 3)
    xaddr_router #(
        .ADDR_W(32), .SEL_ADDR_W(4), .DATA_W(32), .N_SLV(4),
        .SLV_BASE(16'h1215), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid(m_valid), .m_addr(m_addr), .m_we(m_we),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .trap(trap), .err_code(err_code),
        .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata)
    );

    // Called just after a negedge with the router idle; returns just after
    // the negedge following the completion pulse (router idle again).
    task automatic do_req(input string name, input logic [31:0] addr, input logic we,
                          input int ready_after, input logic [31:0] data,
                          input logic [3:0] exp_sv, input int exp_cnt,
                          input logic [31:0] exp_rd, input logic [1:0] exp_err);
        int slot = 0;
        int cnt = 0;
        int n = 0;
        bit done = 0;
        for (int i = 0; i < 4; i++) if (exp_sv[i]) slot = i;
        checks++;
        if (m_ready !== 1'b1) begin errors++; $display("FAIL %s m_ready before accept: got %b exp 1", name, m_ready); end
        m_valid = 1'b1; m_addr = addr; m_we = we;
        // Non-selected slaves report ready with junk data; must be ignored.
        s_ready = ~exp_sv;
        for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = 32'hDEAD_0000 | i;
        @(posedge clk); #1;
        m_valid = 1'b0; m_addr = ~addr; m_we = ~we;
        while (!done && n < 60) begin
            @(negedge clk); n++;
            if (m_rvalid) done = 1;
            else begin
                if (s_valid !== 4'b0) begin
                    checks++; cnt++;
                    if (s_valid !== exp_sv) begin errors++; $display("FAIL %s s_valid: got %b exp %b", name, s_valid, exp_sv); end
                end
                if (ready_after != 0 && cnt == ready_after) begin
                    s_ready[slot] = 1'b1; s_rdata[slot*32 +: 32] = data;
                end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL %s no m_rvalid within 60 cycles", name); end
        checks++;
        if (n !== exp_cnt + 1) begin errors++; $display("FAIL %s latency: got %0d exp %0d", name, n, exp_cnt + 1); end
        checks++;
        if (cnt !== exp_cnt) begin errors++; $display("FAIL %s s_valid cycles: got %0d exp %0d", name, cnt, exp_cnt); end
        checks++;
        if (m_rdata !== exp_rd) begin errors++; $display("FAIL %s m_rdata: got %h exp %h", name, m_rdata, exp_rd); end
        checks++;
        if (err_code !== exp_err) begin errors++; $display("FAIL %s err_code: got %0d exp %0d", name, err_code, exp_err); end
        checks++;
        if (trap !== (exp_err != 2'd0)) begin errors++; $display("FAIL %s trap: got %b exp %b", name, trap, exp_err != 2'd0); end
        checks++;
        if (s_valid !== 4'b0 || m_ready !== 1'b0) begin errors++; $display("FAIL %s at rvalid s_valid/m_ready: got %b/%b exp 0000/0", name, s_valid, m_ready); end
        s_ready = '0;
        @(negedge clk);
        checks++;
        if (m_rvalid !== 1'b0 || trap !== 1'b0 || m_ready !== 1'b1) begin
            errors++; $display("FAIL %s after pulse rvalid/trap/ready: got %b/%b/%b exp 0/0/1", name, m_rvalid, trap, m_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (m_ready !== 1'b1 || s_valid !== 4'b0 || m_rvalid !== 1'b0 || trap !== 1'b0 ||
            err_code !== 2'd0 || m_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset ready/sv/rvalid/trap/err/rdata: got %b/%b/%b/%b/%0d/%h exp 1/0000/0/0/0/0",
                     m_ready, s_valid, m_rvalid, trap, err_code, m_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        do_req("read_tag2", 32'h2000_0010, 1'b0, 3, 32'h1234_5678, 4'b0100, 3, 32'h1234_5678, 2'd0);
        do_req("write_tag2", 32'h2000_0020, 1'b1, 1, 32'hCAFE_F00D, 4'b0100, 1, 32'h0, 2'd0);
    endtask

    task automatic test_alias();
        do_req("tag0_alias", 32'h0000_0100, 1'b0, 2, 32'h0000_AAAA, 4'b0001, 2, 32'h0000_AAAA, 2'd0);
        do_req("tag5_slot0", 32'h5000_0000, 1'b0, 1, 32'h5555_0005, 4'b0001, 1, 32'h5555_0005, 2'd0);
        do_req("dup_tag1", 32'h1ABC_0000, 1'b0, 2, 32'h1111_2222, 4'b0010, 2, 32'h1111_2222, 2'd0);
    endtask

    task automatic test_unmapped();
        do_req("unmap_F", 32'hF000_0000, 1'b0, 0, 32'h0, 4'b0000, 0, 32'h0, 2'd1);
        do_req("unmap_3", 32'h3000_0004, 1'b1, 0, 32'h0, 4'b0000, 0, 32'h0, 2'd1);
    endtask

    task automatic test_timeout();
`ifdef XROUTER_TIMEOUT_EN
        do_req("timeout", 32'h2000_0000, 1'b0, 0, 32'h0, 4'b0100, 8, 32'h0, 2'd2);
        do_req("ready_on_expiry", 32'h2000_0000, 1'b0, 8, 32'h8888_0008, 4'b0100, 8, 32'h8888_0008, 2'd0);
`else
        do_req("long_wait", 32'h2000_0000, 1'b0, 20, 32'h2020_2020, 4'b0100, 20, 32'h2020_2020, 2'd0);
`endif
    endtask

    task automatic test_back_to_back();
        do_req("b2b_a", 32'h1000_0000, 1'b0, 1, 32'hA0A0_A0A0, 4'b0010, 1, 32'hA0A0_A0A0, 2'd0);
        do_req("b2b_b", 32'h2000_0000, 1'b0, 1, 32'hB0B0_B0B0, 4'b0100, 1, 32'hB0B0_B0B0, 2'd0);
        do_req("b2b_c", 32'hE000_0000, 1'b0, 0, 32'h0, 4'b0000, 0, 32'h0, 2'd1);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        m_valid = 1'b1; m_addr = 32'h1000_0000; m_we = 1'b0;
        @(posedge clk); #1;
        m_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (s_valid !== 4'b0010) begin errors++; $display("FAIL rst_mid s_valid before reset: got %b exp 0010", s_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (s_valid !== 4'b0 || m_ready !== 1'b1 || m_rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_mid during reset sv/ready/rvalid: got %b/%b/%b exp 0000/1/0", s_valid, m_ready, m_rvalid);
        end
        s_ready = 4'b0010; s_rdata[32 +: 32] = 32'h7777_7777;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (m_rvalid !== 1'b0 || s_valid !== 4'b0) seen++;
        end
        s_ready = '0;
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rst_mid activity after reset: got %0d cycles exp 0", seen); end
        checks++;
        if (m_ready !== 1'b1) begin errors++; $display("FAIL rst_mid m_ready after release: got %b exp 1", m_ready); end
        do_req("after_rst", 32'h2000_0000, 1'b0, 1, 32'h0BAD_CAFE, 4'b0100, 1, 32'h0BAD_CAFE, 2'd0);
    endtask

    initial begin
        test_reset();
        test_read();
        test_alias();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
